// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: binary-to-BCD conversion (double-dabble) and
// time-multiplexed 4-digit 7-segment scan with leading-zero blanking.
module display_scan_ctrl #(
    parameter int N_in        = 10,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_in-1:0] bin_in,
    input  logic            bin_valid,
    output logic            bin_ready,
    output logic [3:0]      bcd_digit,
    output logic [3:0]      an_n,
    output logic            ovf,
    output logic            done
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic [N_in-1:0] r_sh;
    logic [15:0]     r_scr;
    logic            r_scr_ovf;
    logic [15:0]     r_dig;
    logic            r_ovf;
    logic [PW-1:0]   r_pre;
    logic [1:0]      r_idx;
    logic [3:0]      r_an;
    logic [3:0]      r_bcd;

    logic            w_hs;
    logic            w_last;
    logic [15:0]     w_adj;
    logic [15:0]     w_scr_nxt;
    logic            w_ovf_nxt;
    logic [3:0]      w_blank;
    logic [3:0]      w_sel_dig;
    logic [3:0]      w_an;
    logic [3:0]      w_bcd;

    assign w_hs   = bin_valid && (r_state == IDLE);
    assign w_last = (r_cnt == 4'(N_in - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state and handshake/done outputs
    always_comb begin
        w_next    = r_state;
        bin_ready = 1'b0;
        done      = 1'b0;
        case (r_state)
            IDLE: begin
                bin_ready = 1'b1;
                if (bin_valid) w_next = CONVERT;
            end
            CONVERT: begin
                if (w_last) w_next = COMMIT;
            end
            COMMIT: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Add-3 on every nibble >= 5, then shift the next binary bit in;
    // a bit carried out of the top nibble means the value exceeds 9999
    always_comb begin
        w_adj = r_scr;
        for (int i = 0; i < 4; i++) begin
            if (r_scr[i*4 +: 4] >= 4'd5)
                w_adj[i*4 +: 4] = r_scr[i*4 +: 4] + 4'd3;
        end
        w_scr_nxt = {w_adj[14:0], r_sh[N_in-1]};
        w_ovf_nxt = r_scr_ovf | w_adj[15];
    end

    // Conversion datapath; digits load together as COMMIT is entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_sh      <= '0;
            r_scr     <= '0;
            r_scr_ovf <= 1'b0;
            r_dig     <= '0;
            r_ovf     <= 1'b0;
        end else if (w_hs) begin
            r_cnt     <= '0;
            r_sh      <= bin_in;
            r_scr     <= '0;
            r_scr_ovf <= 1'b0;
        end else if (r_state == CONVERT) begin
            r_cnt     <= r_cnt + 4'd1;
            r_sh      <= r_sh << 1;
            r_scr     <= w_scr_nxt;
            r_scr_ovf <= w_ovf_nxt;
            if (w_last) begin
                r_dig <= w_ovf_nxt ? 16'h9999 : w_scr_nxt;
                r_ovf <= w_ovf_nxt;
            end
        end
    end

    // Free-running prescaler advances the scan index at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= 2'd0;
        end else if (r_pre == PW'(REFRESH_DIV - 1)) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Leading-zero detection and digit/enable selection for the slot
    always_comb begin
        w_blank[3] = (BLANK_LZ != 0) && (r_dig[15:12] == 4'h0);
        w_blank[2] = w_blank[3] && (r_dig[11:8] == 4'h0);
        w_blank[1] = w_blank[2] && (r_dig[7:4] == 4'h0);
        w_blank[0] = 1'b0;
        w_sel_dig  = r_dig[{r_idx, 2'b00} +: 4];
        if (w_blank[r_idx]) begin
            w_an  = 4'b1111;
            w_bcd = 4'hF;
        end else begin
            w_an  = ~(4'b0001 << r_idx);
            w_bcd = w_sel_dig;
        end
    end

    // Registered digit enable and BCD code, always updated together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'b1110;
            r_bcd <= 4'h0;
        end else begin
            r_an  <= w_an;
            r_bcd <= w_bcd;
        end
    end

    assign an_n      = r_an;
    assign bcd_digit = r_bcd;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed vectors for display_scan_ctrl,
// one 10-bit unblanked instance and one 14-bit blanked instance.
module tb_display_scan_ctrl;

    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [9:0]  bin0;
    logic [13:0] bin1;
    logic        v0, v1;
    logic        rdy0, rdy1;
    logic [3:0]  bcd0, bcd1;
    logic [3:0]  an0, an1;
    logic        ovf0, ovf1;
    logic        done0, done1;

    int checks;
    int errors;
    int ecount;

    typedef struct {
        int          sel;
        int          val;
        logic [15:0] dig;
        logic        ovf;
    } vec_t;

    vec_t tbl[12];

    display_scan_ctrl #(.N_in(10), .REFRESH_DIV(DIV), .BLANK_LZ(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bin_in(bin0), .bin_valid(v0),
        .bin_ready(rdy0), .bcd_digit(bcd0), .an_n(an0),
        .ovf(ovf0), .done(done0)
    );

    display_scan_ctrl #(.N_in(14), .REFRESH_DIV(DIV), .BLANK_LZ(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bin_in(bin1), .bin_valid(v1),
        .bin_ready(rdy1), .bcd_digit(bcd1), .an_n(an1),
        .ovf(ovf1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since reset release, used to predict the scan slot
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_out(int slot, logic [15:0] d, bit blk);
        logic        b3, b2, b1, bl;
        logic [3:0]  an;
        logic [15:0] t;
        b3 = blk && (d[15:12] == 4'h0);
        b2 = b3 && (d[11:8] == 4'h0);
        b1 = b2 && (d[7:4] == 4'h0);
        case (slot)
            3: bl = b3;
            2: bl = b2;
            1: bl = b1;
            default: bl = 1'b0;
        endcase
        if (bl) return 8'hFF;
        an = 4'b1111;
        an[slot] = 1'b0;
        t = d >> (4 * slot);
        return {an, t[3:0]};
    endfunction

    task automatic scan(int s, logic [15:0] d);
        int          slot;
        logic [7:0]  e;
        repeat (4 * DIV) begin
            @(negedge clk);
            slot = (ecount == 0) ? 0 : ((ecount - 1) / DIV) % 4;
            e = exp_out(slot, d, s == 1);
            chk($sformatf("scan%0d slot%0d val%0h", s, slot, d),
                s == 1 ? {an1, bcd1} : {an0, bcd0}, e);
        end
    endtask

    task automatic load(int s, int val, int inj_cyc, int inj_val,
                        logic exp_ovf);
        int   n;
        int   k;
        int   done_k;
        int   rdy_k;
        logic rdy;
        n = (s == 1) ? 14 : 10;
        @(negedge clk);
        chk($sformatf("ready_before%0d", val), s == 1 ? rdy1 : rdy0, 1);
        if (s == 1) begin bin1 = 14'(val); v1 = 1'b1; end
        else        begin bin0 = 10'(val); v0 = 1'b1; end
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
        k = 1;
        done_k = -1;
        rdy_k = -1;
        while (k < 60 && rdy_k < 0) begin
            rdy = (s == 1) ? rdy1 : rdy0;
            if ((s == 1) ? done1 : done0) begin
                if (done_k < 0) done_k = k;
                chk($sformatf("ovf%0d", val), s == 1 ? ovf1 : ovf0, exp_ovf);
            end
            if (rdy) rdy_k = k;
            if (k == inj_cyc) begin
                if (s == 1) begin bin1 = 14'(inj_val); v1 = 1'b1; end
                else        begin bin0 = 10'(inj_val); v0 = 1'b1; end
            end else begin
                v0 = 1'b0;
                v1 = 1'b0;
            end
            if (rdy_k < 0) begin
                @(negedge clk);
                k++;
            end
        end
        v0 = 1'b0;
        v1 = 1'b0;
        chk($sformatf("done_cycle%0d", val), done_k, n + 1);
        chk($sformatf("ready_cycle%0d", val), rdy_k, n + 2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl[0]  = '{0, 1023,  16'h1023, 1'b0};
        tbl[1]  = '{0, 999,   16'h0999, 1'b0};
        tbl[2]  = '{0, 0,     16'h0000, 1'b0};
        tbl[3]  = '{1, 7,     16'h0007, 1'b0};
        tbl[4]  = '{1, 12345, 16'h9999, 1'b1};
        tbl[5]  = '{1, 42,    16'h0042, 1'b0};
        tbl[6]  = '{1, 0,     16'h0000, 1'b0};
        tbl[7]  = '{1, 9999,  16'h9999, 1'b0};
        tbl[8]  = '{1, 10000, 16'h9999, 1'b1};
        tbl[9]  = '{1, 305,   16'h0305, 1'b0};
        tbl[10] = '{1, 1000,  16'h1000, 1'b0};
        tbl[11] = '{1, 16383, 16'h9999, 1'b1};

        rst_n = 1'b0;
        v0 = 1'b0;
        v1 = 1'b0;
        bin0 = '0;
        bin1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_an0", an0, 4'b1110);
        chk("rst_bcd0", bcd0, 4'h0);
        chk("rst_ready0", rdy0, 1);
        chk("rst_ovf0", ovf0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_an1", an1, 4'b1110);
        rst_n = 1'b1;
        repeat (DIV + 1) @(negedge clk);
        chk("scan_after_div_an", an0, 4'b1101);
        chk("scan_after_div_bcd", bcd0, 4'h0);
        scan(0, 16'h0000);

        for (int i = 0; i < 12; i++) begin
            load(tbl[i].sel, tbl[i].val, 0, 0, tbl[i].ovf);
            chk($sformatf("ovf_hold%0d", tbl[i].val),
                tbl[i].sel == 1 ? ovf1 : ovf0, tbl[i].ovf);
            scan(tbl[i].sel, tbl[i].dig);
        end

        load(0, 500, 3, 321, 1'b0);
        scan(0, 16'h0500);

        @(negedge clk);
        bin0 = 10'd777;
        v0 = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_convert_busy", rdy0, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_ready0", rdy0, 1);
        chk("abort_an0", an0, 4'b1110);
        chk("abort_bcd0", bcd0, 4'h0);
        chk("abort_ovf1", ovf1, 0);
        chk("abort_done0", done0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        scan(0, 16'h0000);
        scan(1, 16'h0000);
        load(0, 88, 0, 0, 1'b0);
        scan(0, 16'h0088);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Sequencing controller for the 4-digit 7-segment display datapath.
- Accepts a binary value through a valid/ready handshake and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the four digits onto one shared BCD_module decoder and drives one-hot active-low digit enables.
- Sits between the value source (switches/counter logic) and the single shared decoder plus the board digit-select pins.

Parameters:
- N_in, 10: width of the binary input value; legal range 4..14.
- REFRESH_DIV, 50000: clock cycles each digit stays enabled; must be at least 2.
- BLANK_LZ, 1: 1 blanks leading-zero digits; 0 shows every digit.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- bin_in  input  N_in  binary value to display.
- bin_valid  input  1  bin_in is valid this cycle.
- bin_ready  output  1  controller can accept a value.
- bcd_digit  output  4  BCD code of the active digit, to the shared decoder's BCD_in.
- an_n  output  4  digit enables, active-low, one-hot; bit0 = units, bit3 = thousands.
- ovf  output  1  the last committed value exceeded 9999.
- done  output  1  one-cycle pulse when new digits are committed.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Digit registers are all 0; scan index is 0; prescaler is 0.
  - an_n = 4'b1110, bcd_digit = 0, bin_ready = 1, ovf = 0, done = 0.
  - The state machine goes to IDLE.
- States:
  - IDLE: bin_ready = 1.
  - CONVERT: bin_ready = 0.
  - COMMIT: bin_ready = 0.
- Transitions:
  - IDLE -> CONVERT on a handshake (bin_valid & bin_ready). bin_in is captured into the shift register; the BCD scratch register is cleared.
  - CONVERT runs exactly N_in cycles. Each cycle, any BCD nibble >= 5 gets +3, then the combined register shifts left by one.
  - CONVERT -> COMMIT after the N_in-th shift.
  - COMMIT -> IDLE after one cycle. In the COMMIT cycle, the digit registers load atomically from scratch and done = 1.
- Latency: handshake at cycle 0 -> digits and done valid at cycle N_in+1 -> bin_ready = 1 at cycle N_in+2.
- Arithmetic:
  - The scratch register is 16 bits (4 nibbles) plus an overflow flag.
  - If the captured value is > 9999, the committed digits are forced to 9,9,9,9 and ovf = 1.
  - Otherwise ovf = 0 at commit.
- Handshake:
  - bin_valid while bin_ready = 0 is ignored; no queuing.
  - bin_in only needs to be stable in the handshake cycle.
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1 continuously and independently of the state machine.
  - At terminal count, the scan index advances 0->1->2->3->0 and the prescaler wraps to 0.
  - an_n and bcd_digit are registered. They update in the cycle after the index changes and always match each other.
  - During CONVERT, the previously committed digits continue to be displayed; there is no tearing.
- Blanking (BLANK_LZ=1):
  - A digit is blank if it and every more-significant digit is 0. The units digit is never blank.
  - A blank digit drives an_n = 4'b1111 for its slot and bcd_digit = 4'hF.
  - Value 0 shows "0" on units only.
- Reset mid-CONVERT aborts the conversion, and the display shows 0 (digits cleared).
- Deassertion of reset takes effect on the next clock edge; no synchronizer is internal to this block.

Test Plan:
- Reset with BLANK_LZ=0 -> an_n=4'b1110, bcd_digit=0, bin_ready=1, ovf=0; after REFRESH_DIV cycles an_n=4'b1101 with bcd_digit=0.
- Load 1023 (N_in=10) -> bin_ready low for 11 cycles, done pulse at cycle 11; scan shows units=3, tens=2, hundreds=0, thousands=1 in slot order.
- Load 7 with BLANK_LZ=1 -> units slot shows 7; tens/hundreds/thousands slots have an_n=4'b1111 and bcd_digit=4'hF.
- N_in=14, load 12345 -> digits 9,9,9,9, ovf=1; then load 42 -> ovf=0, digits 0,0,4,2.
- Load 500, then pulse bin_valid with 321 at cycle 3 of CONVERT -> ignored; display commits 500, and bin_ready returns at cycle N_in+2.
- Assert rst_n low at cycle 5 of CONVERT -> immediate return to reset values; display shows 0; the next load of 88 completes normally.
